// File: rtl/hex_inverter_tester_if.sv
// Bundles the tester's board-side signals (start button, status LEDs) and
// the gate-package bus (a drives the six inverter inputs, y returns outputs).
//   start          : level, begins a test run when the tester is idle
//   a[5:0]         : package inputs, a[0]=a1 ... a[5]=a6
//   y[5:0]         : package outputs, y[0]=y1 ... y[5]=y6 (synchronous to clk)
//   busy, done     : run in progress / one-cycle end-of-run pulse
//   pass           : last completed run had zero errors
//   fail_mask      : sticky OR of per-gate mismatches over the last run
//   err_count      : number of vectors with any mismatch (0..64)
//   first_fail_vec : index of the first failing vector, 0 if none
interface hex_inverter_tester_if;
    logic       start;
    logic [5:0] a;
    logic [5:0] y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_mask;
    logic [6:0] err_count;
    logic [5:0] first_fail_vec;

    // Tester side.
    modport master (
        input  start,
        input  y,
        output a,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_count,
        output first_fail_vec
    );

    // Board / package side.
    modport slave (
        output start,
        output y,
        input  a,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_count,
        input  first_fail_vec
    );
endinterface

// File: rtl/hex_inverter_tester.sv
// Sequencing controller for one six-gate inverter package. On start it walks
// all 64 input patterns onto a, waits SETTLE_CYCLES for the gates to
// propagate, then compares y against ~a and accumulates the results.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : hex_inverter_tester_if.master (start, a, y and result outputs)
// Parameter:
//   SETTLE_CYCLES : cycles between applying a vector and sampling y (>= 1,
//                   must cover the package propagation delay)
module hex_inverter_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    hex_inverter_tester_if.master  bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       vec_q, vec_d;
    logic [5:0]       a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [5:0]       mask_q, mask_d;
    logic [6:0]       err_q, err_d;
    logic [5:0]       ffv_q, ffv_d;
    logic             seen_q, seen_d;
    logic [5:0]       mism;

    // A good inverter gives y == ~a, so any set bit here is a failing gate.
    assign mism = bus.y ^ ~a_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        vec_d   = vec_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        seen_d  = seen_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_APPLY;
                    vec_d   = 6'd0;
                    a_d     = 6'd0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    mask_d  = 6'd0;
                    err_d   = 7'd0;
                    ffv_d   = 6'd0;
                    seen_d  = 1'b0;
                end
            end
            S_APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mism != 6'd0) begin
                    mask_d = mask_q | mism;
                    err_d  = err_q + 7'd1;
                    if (!seen_q) begin
                        ffv_d  = vec_q;
                        seen_d = 1'b1;
                    end
                end
                if (vec_q == 6'd63) begin
                    // Results become visible together with the done pulse.
                    state_d = S_DONE;
                    a_d     = 6'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 7'd0);
                end else begin
                    state_d = S_APPLY;
                    vec_d   = vec_q + 6'd1;
                    a_d     = vec_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= 6'd0;
            a_q     <= 6'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 6'd0;
            err_q   <= 7'd0;
            ffv_q   <= 6'd0;
            seen_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.a              = a_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.fail_mask      = mask_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_hex_inverter_tester.sv
// Bench for hex_inverter_tester: two testers (SETTLE_CYCLES=4 and 1) each
// drive a behavioural inverter package with fixed lag and optional
// stuck-at faults. Table rows cover full runs; hand-written sequences cover
// mid-run reset, start re-pulse and start held high.
module tb_hex_inverter_tester;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_inverter_tester_if if4 ();
    hex_inverter_tester_if if1 ();

    hex_inverter_tester #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .reset(rst), .bus(if4.master));
    hex_inverter_tester #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.master));

    logic [1:0] start_v;
    logic [5:0] s0_v [2];   // stuck-at-0 bits per package
    logic [5:0] s1_v [2];   // stuck-at-1 bits per package

    // Package model: registered delay line of a, output inverted.
    logic [5:0] pipe4 [3];
    logic [5:0] pipe1 [3];
    always @(posedge clk) begin
        pipe4[0] <= if4.a; pipe4[1] <= pipe4[0]; pipe4[2] <= pipe4[1];
        pipe1[0] <= if1.a; pipe1[1] <= pipe1[0]; pipe1[2] <= pipe1[1];
    end

    function automatic logic [5:0] pkg_y(input logic [5:0] d, input logic [5:0] s0,
                                         input logic [5:0] s1);
        return (~d & ~s0) | s1;
    endfunction

    assign if4.start = start_v[0];
    assign if1.start = start_v[1];
    assign if4.y     = pkg_y(pipe4[1], s0_v[0], s1_v[0]);   // 2-cycle lag
    assign if1.y     = pkg_y(pipe1[2], s0_v[1], s1_v[1]);   // 3-cycle lag

    logic       done_w [2];
    logic       busy_w [2];
    logic       pass_w [2];
    logic [5:0] a_w    [2];
    logic [5:0] mask_w [2];
    logic [6:0] err_w  [2];
    logic [5:0] ffv_w  [2];
    assign done_w[0] = if4.done;           assign done_w[1] = if1.done;
    assign busy_w[0] = if4.busy;           assign busy_w[1] = if1.busy;
    assign pass_w[0] = if4.pass;           assign pass_w[1] = if1.pass;
    assign a_w[0]    = if4.a;              assign a_w[1]    = if1.a;
    assign mask_w[0] = if4.fail_mask;      assign mask_w[1] = if1.fail_mask;
    assign err_w[0]  = if4.err_count;      assign err_w[1]  = if1.err_count;
    assign ffv_w[0]  = if4.first_fail_vec; assign ffv_w[1]  = if1.first_fail_vec;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launches a run on tester sel; cycle 1 is the cycle after the edge that
    // samples start. Returns the cycle holding done (-1 on timeout).
    task automatic run(input int sel, input bit hold, input int repulse_at,
                       output int done_cyc, output logic busy_at1);
        int cyc;
        bit got;
        cyc      = 0;
        got      = 0;
        done_cyc = -1;
        busy_at1 = 1'b0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        while (!got && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start_v[sel] = (repulse_at > 0 && cyc == repulse_at);
            if (cyc == 1) busy_at1 = busy_w[sel];
            if (done_w[sel]) begin
                got      = 1;
                done_cyc = cyc;
            end
        end
    endtask

    typedef struct {
        int         sel;
        logic [5:0] s0;
        logic [5:0] s1;
        int         exp_done;
        logic       exp_pass;
        logic [5:0] exp_mask;
        logic [6:0] exp_err;
        logic [5:0] exp_ffv;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int   dc;
        int   cyc;
        logic b1;
        bit   saw_done;

        tbl[0] = '{0, 6'b000000, 6'b000000, 385, 1'b1, 6'b000000, 7'd0,  6'd0};
        tbl[1] = '{0, 6'b000100, 6'b000000, 385, 1'b0, 6'b000100, 7'd32, 6'd0};
        tbl[2] = '{0, 6'b000000, 6'b000001, 385, 1'b0, 6'b000001, 7'd32, 6'd1};
        tbl[3] = '{1, 6'b000000, 6'b000000, 193, 1'b0, 6'b111111, 7'd63, 6'd1};

        rst     = 1'b1;
        start_v = 2'b00;
        s0_v[0] = '0; s0_v[1] = '0;
        s1_v[0] = '0; s1_v[1] = '0;
        repeat (3) @(negedge clk);

        check("reset_a",    a_w[0],    0);
        check("reset_busy", busy_w[0], 0);
        check("reset_done", done_w[0], 0);
        check("reset_pass", pass_w[0], 0);
        check("reset_mask", mask_w[0], 0);
        check("reset_err",  err_w[0],  0);
        check("reset_ffv",  ffv_w[0],  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            s0_v[tbl[i].sel] = tbl[i].s0;
            s1_v[tbl[i].sel] = tbl[i].s1;
            run(tbl[i].sel, 1'b0, 0, dc, b1);
            check($sformatf("row%0d_busy_c1", i), b1, 1);
            check($sformatf("row%0d_done_cyc", i), dc, tbl[i].exp_done);
            check($sformatf("row%0d_pass", i), pass_w[tbl[i].sel], tbl[i].exp_pass);
            check($sformatf("row%0d_mask", i), mask_w[tbl[i].sel], tbl[i].exp_mask);
            check($sformatf("row%0d_err", i), err_w[tbl[i].sel], tbl[i].exp_err);
            check($sformatf("row%0d_ffv", i), ffv_w[tbl[i].sel], tbl[i].exp_ffv);
            repeat (3) @(negedge clk);
            check($sformatf("row%0d_err_hold", i), err_w[tbl[i].sel], tbl[i].exp_err);
            check($sformatf("row%0d_busy_idle", i), busy_w[tbl[i].sel], 0);
            s0_v[tbl[i].sel] = '0;
            s1_v[tbl[i].sel] = '0;
        end

        // Reset in the middle of vector 20 (cycles 121..126), y3 stuck at 0.
        s0_v[0] = 6'b000100;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (122) @(negedge clk);
        check("midrun_a", a_w[0], 20);
        check("midrun_err", err_w[0], 12);
        rst = 1'b1;
        #1;
        check("abort_a",    a_w[0],    0);
        check("abort_busy", busy_w[0], 0);
        check("abort_err",  err_w[0],  0);
        check("abort_mask", mask_w[0], 0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_w[0]) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        s0_v[0] = '0;
        run(0, 1'b0, 0, dc, b1);
        check("after_abort_done_cyc", dc, 385);
        check("after_abort_pass", pass_w[0], 1);
        check("after_abort_err", err_w[0], 0);

        // start re-pulsed mid-run must not disturb the schedule.
        repeat (2) @(negedge clk);
        run(0, 1'b0, 100, dc, b1);
        check("repulse_done_cyc", dc, 385);
        check("repulse_pass", pass_w[0], 1);

        // start held high: second run starts right after IDLE, clears results.
        repeat (2) @(negedge clk);
        s0_v[0] = 6'b000100;
        run(0, 1'b1, 0, dc, b1);
        check("hold_done_cyc", dc, 385);
        check("hold_err1", err_w[0], 32);
        @(negedge clk);   // cycle 386: IDLE
        check("hold_idle_busy", busy_w[0], 0);
        check("hold_idle_err", err_w[0], 32);
        @(negedge clk);   // cycle 387: APPLY of the second run
        check("hold_rerun_busy", busy_w[0], 1);
        check("hold_rerun_err", err_w[0], 0);
        check("hold_rerun_mask", mask_w[0], 0);
        start_v[0] = 1'b0;
        cyc = 387;
        while (!done_w[0] && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_done2_cyc", cyc, 771);
        check("hold_err2", err_w[0], 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
